// File: rtl/bist_pkg.sv
// Shared types and constants for the exhaustive sweep BIST block.
// The FSM encoding, the default MISR polynomial and the dwell-counter sizing helper.
package bist_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } state_t;

  localparam logic [15:0] DEFAULT_POLY = 16'h1021;

  // Width needed to count 0..n-1, never less than one bit.
  function automatic int clog2(input int n);
    int w;
    w = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << w) < n) w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/exhaustive_sweep_bist_misr_reg.sv
// Multiple-input signature register: shift left, fold POLY in when the MSB leaves,
// and XOR in the zero-extended input word. clr has priority over en.
module misr_reg #(
  parameter int              SIG_W  = 16,
  parameter int              N_IN_W = 1,
  parameter logic [SIG_W-1:0] POLY  = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [N_IN_W-1:0] din,
  output logic [SIG_W-1:0]  sig,
  output logic [SIG_W-1:0]  sig_next
);

  logic [SIG_W-1:0] din_ext;

  always_comb begin
    din_ext  = SIG_W'(din);
    sig_next = {sig[SIG_W-2:0], 1'b0} ^ (sig[SIG_W-1] ? POLY : '0) ^ din_ext;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig <= '0;
    end else if (clr) begin
      sig <= '0;
    end else if (en) begin
      sig <= sig_next;
    end
  end

endmodule

// File: rtl/exhaustive_sweep_bist.sv
// Steps an N_IN-bit vector through every value, holding each for DWELL cycles,
// and compacts the DUT response sampled on the last dwell cycle into a MISR.
module exhaustive_sweep_bist
  import bist_pkg::*;
#(
  parameter int               N_IN     = 4,
  parameter int               N_OUT    = 1,
  parameter int               DWELL    = 10,
  parameter int               SIG_W    = 16,
  parameter logic [SIG_W-1:0] SIG_POLY = SIG_W'(DEFAULT_POLY)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [N_OUT-1:0] resp_in,
  input  logic [SIG_W-1:0] expected_sig,
  output logic [N_IN-1:0]  vec_out,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [SIG_W-1:0] signature,
  output logic [N_IN:0]    ones_count,
  output logic             pass,
  output logic             fail,
  output state_t           fsm_state
);

  localparam int              DW         = clog2(DWELL);
  localparam logic [DW-1:0]   DWELL_LAST = DW'(DWELL - 1);
  localparam logic [N_IN-1:0] VEC_LAST   = '1;

  state_t           state;
  state_t           state_next;
  logic [DW-1:0]    dwell;
  logic             start_go;
  logic             sample;
  logic             last_sample;
  logic [SIG_W-1:0] sig_next;

  // Handshake: start is a level sampled only in IDLE with abort low; abort is
  // honoured only in SWEEP and beats a coincident final sample.

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (start && !abort) state_next = ST_SWEEP;
      ST_SWEEP: if (abort || last_sample) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    start_go    = (state == ST_IDLE) && start && !abort;
    sample      = (state == ST_SWEEP) && !abort && (dwell == DWELL_LAST);
    last_sample = sample && (vec_out == VEC_LAST);
    busy        = (state == ST_SWEEP);
    fsm_state   = state;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec_out    <= '0;
      dwell      <= '0;
      done       <= 1'b0;
      aborted    <= 1'b0;
      ones_count <= '0;
      pass       <= 1'b0;
      fail       <= 1'b0;
    end else begin
      done <= last_sample;
      if (start_go) begin
        vec_out    <= '0;
        dwell      <= '0;
        ones_count <= '0;
        pass       <= 1'b0;
        fail       <= 1'b0;
        aborted    <= 1'b0;
      end else if (state == ST_SWEEP) begin
        if (abort) begin
          vec_out <= '0;
          dwell   <= '0;
          aborted <= 1'b1;
        end else if (sample) begin
          ones_count <= ones_count + (N_IN + 1)'(resp_in[0]);
          dwell      <= '0;
          if (last_sample) begin
            // Verdict uses the signature including this final response.
            vec_out <= '0;
            pass    <= (sig_next == expected_sig);
            fail    <= (sig_next != expected_sig);
          end else begin
            vec_out <= vec_out + 1'b1;
          end
        end else begin
          dwell <= dwell + 1'b1;
        end
      end
    end
  end

  misr_reg #(
    .SIG_W (SIG_W),
    .N_IN_W(N_OUT),
    .POLY  (SIG_POLY)
  ) u_misr (
    .clk     (clk),
    .rst     (rst),
    .clr     (start_go),
    .en      (sample),
    .din     (resp_in),
    .sig     (signature),
    .sig_next(sig_next)
  );

endmodule

// File: tb/tb_exhaustive_sweep_bist.sv
// Bench for exhaustive_sweep_bist: a 2-input AND sweep (DWELL=1, 8-bit MISR) and a
// 4-input parity sweep with default parameters, with directed expected values.
module tb_exhaustive_sweep_bist;
  import bist_pkg::*;

  logic clk;
  logic rst;

  // Small configuration: N_IN=2, DWELL=1, SIG_W=8, poly 8'h07, DUT = AND
  logic       start_a, abort_a;
  logic [0:0] resp_a;
  logic [7:0] exp_a;
  logic [1:0] vec_a;
  logic       busy_a, done_a, aborted_a, pass_a, fail_a;
  logic [7:0] sig_a;
  logic [2:0] ones_a;
  state_t     st_a;

  // Default configuration: N_IN=4, DWELL=10, SIG_W=16, poly 16'h1021, DUT = parity
  logic        start_b, abort_b;
  logic [0:0]  resp_b;
  logic [15:0] exp_b;
  logic [3:0]  vec_b;
  logic        busy_b, done_b, aborted_b, pass_b, fail_b;
  logic [15:0] sig_b;
  logic [4:0]  ones_b;
  state_t      st_b;

  int checks;
  int errors;

  assign resp_a = &vec_a;
  assign resp_b = ^vec_b;

  exhaustive_sweep_bist #(
    .N_IN(2), .N_OUT(1), .DWELL(1), .SIG_W(8), .SIG_POLY(8'h07)
  ) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .abort(abort_a), .resp_in(resp_a),
    .expected_sig(exp_a), .vec_out(vec_a), .busy(busy_a), .done(done_a),
    .aborted(aborted_a), .signature(sig_a), .ones_count(ones_a), .pass(pass_a),
    .fail(fail_a), .fsm_state(st_a)
  );

  exhaustive_sweep_bist dut_b (
    .clk(clk), .rst(rst), .start(start_b), .abort(abort_b), .resp_in(resp_b),
    .expected_sig(exp_b), .vec_out(vec_b), .busy(busy_b), .done(done_b),
    .aborted(aborted_b), .signature(sig_b), .ones_count(ones_b), .pass(pass_b),
    .fail(fail_b), .fsm_state(st_b)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] exp_in;
    int          restart_at;
    int          abort_at;
    int          exp_busy;
    int          exp_ones;
    logic [15:0] exp_sig;
    logic        exp_pass;
    logic        exp_fail;
    int          exp_done;
    logic        exp_aborted;
  } rec_t;

  rec_t vecs[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // One parity sweep on the default instance, driven from the record.
  task automatic run_b(input int idx);
    rec_t r;
    int   busy_cnt, done_cnt, vec_bad;
    r        = vecs[idx];
    busy_cnt = 0;
    done_cnt = 0;
    vec_bad  = 0;
    @(negedge clk);
    start_b = 1'b1;
    exp_b   = r.exp_in;
    @(negedge clk);
    start_b = 1'b0;
    for (int n = 0; n < 170; n++) begin
      if (busy_b) busy_cnt++;
      if (done_b) done_cnt++;
      if (n < r.exp_busy && vec_b !== 4'(n / 10)) vec_bad++;
      if (r.abort_at >= 0 && n == r.abort_at + 1) begin
        check($sformatf("r%0d abort_busy", idx), busy_b, 0);
        check($sformatf("r%0d abort_vec", idx), vec_b, 0);
        check($sformatf("r%0d abort_flag", idx), aborted_b, 1);
      end
      abort_b = (n == r.abort_at);
      start_b = (n == r.restart_at);
      @(negedge clk);
    end
    abort_b = 1'b0;
    start_b = 1'b0;
    check($sformatf("r%0d vec_hold", idx), vec_bad, 0);
    check($sformatf("r%0d busy_cycles", idx), busy_cnt, r.exp_busy);
    check($sformatf("r%0d done_pulses", idx), done_cnt, r.exp_done);
    check($sformatf("r%0d ones_count", idx), ones_b, r.exp_ones);
    check($sformatf("r%0d signature", idx), sig_b, r.exp_sig);
    check($sformatf("r%0d pass", idx), pass_b, r.exp_pass);
    check($sformatf("r%0d fail", idx), fail_b, r.exp_fail);
    check($sformatf("r%0d aborted", idx), aborted_b, r.exp_aborted);
  endtask

  initial begin
    int bad;
    checks  = 0;
    errors  = 0;
    start_a = 0; abort_a = 0; exp_a = 8'h00;
    start_b = 0; abort_b = 0; exp_b = 16'h0000;

    // Parity over 0..15 is 0110100110010110; the MSB never sets, so the MISR
    // is a plain shift of that pattern: 16'h6996. After vectors 0..4: 16'h000D.
    vecs[0] = '{16'h6996, -1, -1, 160, 8, 16'h6996, 1'b1, 1'b0, 1, 1'b0};
    vecs[1] = '{16'h6997, -1, -1, 160, 8, 16'h6996, 1'b0, 1'b1, 1, 1'b0};
    vecs[2] = '{16'h6996, 50, -1, 160, 8, 16'h6996, 1'b1, 1'b0, 1, 1'b0};
    vecs[3] = '{16'h6996, -1, 53,  54, 3, 16'h000D, 1'b0, 1'b0, 0, 1'b1};

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_vec", vec_b, 0);
    check("reset_busy", busy_b, 0);
    check("reset_sig", sig_b, 0);
    check("reset_pass_fail", {pass_b, fail_b, done_b, aborted_b}, 0);
    rst = 1'b0;
    @(negedge clk);

    // AND sweep: vectors 0,1,2,3 on consecutive cycles, done one cycle later
    start_a = 1'b1;
    exp_a   = 8'h01;
    @(negedge clk);
    start_a = 1'b0;
    bad = 0;
    for (int n = 0; n < 6; n++) begin
      if (vec_a !== ((n < 4) ? 2'(n) : 2'd0)) bad++;
      if (busy_a !== (n < 4)) bad++;
      if (done_a !== (n == 4)) bad++;
      @(negedge clk);
    end
    check("a_sequence", bad, 0);
    check("a_signature", sig_a, 8'h01);
    check("a_ones", ones_a, 1);
    check("a_pass", {pass_a, fail_a}, 2'b10);

    for (int i = 0; i < 4; i++) run_b(i);

    // abort and start together in IDLE: nothing starts, aborted untouched
    abort_b = 1'b1;
    start_b = 1'b1;
    @(negedge clk);
    abort_b = 1'b0;
    start_b = 1'b0;
    check("idle_abort_busy", busy_b, 0);
    check("idle_abort_flag", aborted_b, 1);
    check("idle_abort_sig_held", sig_b, 16'h000D);

    // Asynchronous reset between edges, mid-dwell
    @(negedge clk);
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    repeat (24) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_busy", busy_b, 0);
    check("async_rst_vec", vec_b, 0);
    check("async_rst_sig", sig_b, 0);
    check("async_rst_ones", ones_b, 0);
    check("async_rst_flags", {done_b, aborted_b, pass_b, fail_b}, 0);
    @(negedge clk);
    rst = 1'b0;
    run_b(0);

    // abort on the final sample edge of the AND sweep
    @(negedge clk);
    start_a = 1'b1;
    exp_a   = 8'h01;
    @(negedge clk);
    start_a = 1'b0;
    repeat (3) @(negedge clk);
    abort_a = 1'b1;
    @(negedge clk);
    abort_a = 1'b0;
    check("a_final_abort_done", done_a, 0);
    check("a_final_abort_flag", aborted_a, 1);
    check("a_final_abort_pass", {pass_a, fail_a}, 0);
    check("a_final_abort_busy", busy_a, 0);
    @(negedge clk);
    check("a_final_abort_done_late", done_a, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/exhaustive_sweep_bist.md
Name: exhaustive_sweep_bist

Overview:
- Parametrised, self-timed replacement for hand-written exhaustive stimulus sequences on small combinational blocks.
- Drives every input combination of an N-input DUT (0 to 2^N_IN-1, ascending), holding each vector for DWELL cycles.
- Samples the DUT response on the last dwell cycle of each vector.
- Compacts responses into a MISR signature plus a ones-count, then compares against an expected signature.
- Sits beside the DUT in on-board BIST wrappers; the DUT itself stays purely combinational.

Parameters:
- N_IN, 4, DUT input width, 1..16.
- N_OUT, 1, DUT output width, 1..SIG_W.
- DWELL, 10, clock cycles each vector is held, >=1.
- SIG_W, 16, MISR width, >=N_OUT.
- SIG_POLY, 16'h1021, MISR feedback polynomial (taps XORed in when the MSB shifts out).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a sweep.
- abort  in  1  terminate the sweep in progress.
- resp_in  in  N_OUT  DUT response.
- expected_sig  in  SIG_W  golden signature, sampled at sweep end.
- vec_out  out  N_IN  stimulus vector to the DUT.
- busy  out  1  sweep in progress.
- done  out  1  one-cycle pulse when a sweep completes normally.
- aborted  out  1  sticky flag: last sweep was aborted.
- signature  out  SIG_W  MISR value, held after the sweep.
- ones_count  out  N_IN+1  number of vectors with resp_in[0]==1.
- pass  out  1  signature==expected_sig at completion, held.
- fail  out  1  inverse of pass at completion, held.

Behaviour:
- Reset (asynchronous, any time, including mid-sweep): state=IDLE; vec_out, busy, done, aborted, signature, ones_count, pass and fail all 0; dwell counter 0.
- States and transitions:
  - IDLE -> SWEEP on start==1 && abort==0.
  - SWEEP -> IDLE on abort, or after the final sample.
  - done is a registered pulse; there is no separate DONE state.
- Sweep start, at the edge where start is seen in IDLE:
  - busy<=1, vec_out<=0, dwell<=0.
  - signature<=0, ones_count<=0, pass<=0, fail<=0, aborted<=0.
- Inside SWEEP:
  - dwell counts 0..DWELL-1.
  - At an edge with dwell==DWELL-1 (sample edge):
    - signature <= {signature[SIG_W-2:0],1'b0} ^ (signature[SIG_W-1] ? SIG_POLY : 0) ^ zero-extended resp_in.
    - ones_count += resp_in[0].
    - Then, if vec_out != all-ones: vec_out++, dwell<=0.
    - Else (final sample edge): busy<=0, done<=1, vec_out<=0, state<=IDLE, and pass/fail computed from the post-update signature vs expected_sig.
- Timing: with start seen at edge k, busy is high from edge k to edge k+DWELL*2^N_IN, and done is high for exactly the one cycle following that edge.
- Idle outputs: done falls the next cycle. signature, ones_count, pass and fail hold until the next start or reset.
- start while busy: ignored; no restart and no counter disturbance.
- abort in SWEEP:
  - At that edge: state<=IDLE, busy<=0, vec_out<=0, aborted<=1.
  - done, pass and fail stay 0; signature and ones_count freeze at their last values.
- Simultaneous events:
  - abort on the final sample edge: abort wins, done is not asserted.
  - abort in IDLE: ignored.
  - start and abort together in IDLE: no start.
- Width rules:
  - ones_count is N_IN+1 bits, so a full count of 2^N_IN never wraps.
  - The vector counter is exactly N_IN bits.
  - resp_in is zero-extended to SIG_W before the MISR XOR.

Decomposition:
- Shared package bist_pkg:
  - State encoding constants: ST_IDLE=0, ST_SWEEP=1.
  - Default polynomial constant.
  - Function clog2 for sizing the dwell counter (clog2(DWELL), minimum 1 bit).
- One sub-module, misr_reg, parametrised by SIG_W, N_IN_W and POLY.
  - Inputs: clk, rst, clr, en, din.
  - Output: sig.
  - Instantiated once, with en tied to the sample-edge strobe.

Test Plan:
- N_IN=2, DWELL=1, SIG_W=8, SIG_POLY=8'h07, DUT=AND, expected_sig=8'h01; start at edge k.
  - vec_out steps 0,1,2,3 on consecutive cycles.
  - busy is high for 4 cycles; done pulses after edge k+4.
  - signature=8'h01, ones_count=1, pass=1.
- N_IN=4, DWELL=10, defaults, DUT = 4-input parity.
  - Each vector is held 10 cycles; busy is high for 160 cycles.
  - ones_count=8.
  - pass=1 with expected_sig from the reference model; repeat with expected_sig bit-flipped -> fail=1, pass=0.
- Same configuration, start pulsed again at cycle 50 of the sweep.
  - No restart; total busy stays 160 cycles and the results match the uninterrupted run.
- abort asserted at vector 5, dwell 3.
  - Next cycle: busy=0, vec_out=0, aborted=1.
  - done never pulses; pass=fail=0; ones_count equals the count over vectors 0..4.
- rst asserted asynchronously mid-dwell, between clock edges.
  - All outputs are 0 immediately, without waiting for an edge.
  - A subsequent start runs a full clean sweep with results identical to the parity case.
- abort coincident with the final sample edge (N_IN=2, DWELL=1).
  - done stays 0; aborted=1; pass=0.
